// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Fetch-stage exception codes and the instruction-memory response.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [3:0] {
        E_I_ADDR_MISALIGNED   = 4'h0,
        E_I_ACCESS_FAULT      = 4'h1,
        E_ILLEGAL_INSTRUCTION = 4'h2,
        E_BREAKPOINT          = 4'h3
    } except_code_t;

    typedef struct packed {
        logic [len5_pkg::ILEN-1:0] rdata;
        logic                      except_raised;
        except_code_t              except_code;
    } instr_mem_resp_t;

endpackage
`default_nettype wire

// File: rtl/len5_pkg.sv
`default_nettype none
// ============================================================================
// Module   : len5_pkg
// Brief    : Core-wide architectural widths shared by the fetch path.
// Revision : 1.0 - initial release
// ============================================================================
package len5_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ALEN = 64;
    localparam int unsigned ILEN = 32;

endpackage
`default_nettype wire

// File: rtl/instr_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : instr_resp_fifo
// Brief    : Synchronous FIFO of instruction-memory responses; head is zero
//            whenever the FIFO is empty.
// Revision : 1.0 - initial release
// ============================================================================
module instr_resp_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned COUNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_push,
    input  wire instr_mem_resp_t i_push_data,
    input  wire logic            i_pop,
    output instr_mem_resp_t      o_head,
    output logic                 o_empty,
    output logic [COUNT_W-1:0]   o_count
);

    localparam int unsigned          c_ptr_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned          c_last_int  = DEPTH - 1;
    localparam logic [c_ptr_w-1:0]   c_ptr_last  = c_last_int[c_ptr_w-1:0];
    localparam logic [COUNT_W-1:0]   c_depth_cnt = DEPTH[COUNT_W-1:0];

    logic [c_ptr_w-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_ptr_w-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [COUNT_W-1:0] r_count_q,  w_count_d;
    logic               w_do_push, w_do_pop;
    instr_mem_resp_t    r_mem_q [DEPTH];

    // A push into a full FIFO is only allowed when the head leaves the same cycle.
    always_comb begin
        w_do_pop   = i_pop & (r_count_q != '0);
        w_do_push  = i_push & ((r_count_q != c_depth_cnt) | w_do_pop);
        w_rd_ptr_d = r_rd_ptr_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_count_d  = r_count_q;
        if (w_do_pop) begin
            w_rd_ptr_d = (r_rd_ptr_q == c_ptr_last) ? '0 : r_rd_ptr_q + c_ptr_w'(1);
        end
        if (w_do_push) begin
            w_wr_ptr_d = (r_wr_ptr_q == c_ptr_last) ? '0 : r_wr_ptr_q + c_ptr_w'(1);
        end
        if (w_do_push && !w_do_pop) begin
            w_count_d = r_count_q + COUNT_W'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_d = r_count_q - COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr_q <= '0;
            r_wr_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_rd_ptr_q <= w_rd_ptr_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_q[r_wr_ptr_q] <= i_push_data;
        end
    end

    assign o_empty = (r_count_q == '0);
    assign o_head  = o_empty ? '0 : r_mem_q[r_rd_ptr_q];
    assign o_count = r_count_q;

endmodule
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_responder
// Brief    : Instruction-memory responder: checks fetch requests, reads a
//            1-cycle SRAM and returns in-order responses with back-pressure.
//            Optional INSTR_MEM_RESP_STALL_EN adds LFSR request back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_responder
    import len5_pkg::*;
    import fetch_pkg::*;
#(
    parameter logic [ALEN-1:0] MEM_BASE        = '0,
    parameter int unsigned     MEM_SIZE        = 4096,
    parameter int unsigned     MAX_OUTSTANDING = 3,
    parameter int unsigned     SRAM_AW         = $clog2(MEM_SIZE / 4)
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,
    input  wire logic               instr_valid_i,
    output logic                    instr_ready_o,
    input  wire logic               instr_we_i,
    input  wire logic [ALEN-1:0]    instr_addr_i,
    output logic                    instr_valid_o,
    input  wire logic               instr_ready_i,
    output logic [ILEN-1:0]         instr_rdata_o,
    output logic                    instr_except_raised_o,
    output except_code_t            instr_except_code_o,
    output logic                    sram_req_o,
    output logic [SRAM_AW-1:0]      sram_addr_o,
    input  wire logic [ILEN-1:0]    sram_rdata_i
);

    localparam int unsigned        c_cnt_w   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_cnt_w:0]   c_max_cnt = MAX_OUTSTANDING[c_cnt_w:0];
    localparam logic [ALEN-1:0]    c_mem_end = MEM_BASE + ALEN'(MEM_SIZE);

    logic               r_s1_valid_q,  w_s1_valid_d;
    logic               r_s1_except_q, w_s1_except_d;
    except_code_t       r_s1_code_q,   w_s1_code_d;

    logic               w_accept;
    logic               w_misaligned;
    logic               w_out_of_range;
    logic               w_fault;
    except_code_t       w_code;
    logic [SRAM_AW-1:0] w_word_idx;
    logic [c_cnt_w:0]   w_count;
    logic               w_stall;
    logic               w_pop;
    logic               w_fifo_empty;
    logic [c_cnt_w-1:0] w_fifo_count;
    instr_mem_resp_t    w_push_data;
    instr_mem_resp_t    w_head;

`ifdef INSTR_MEM_RESP_STALL_EN
    logic [7:0] r_lfsr_q, w_lfsr_d;

    // Fibonacci LFSR, taps 8,6,5,4.
    always_comb begin
        w_lfsr_d = {r_lfsr_q[6:0], r_lfsr_q[7] ^ r_lfsr_q[5] ^ r_lfsr_q[4] ^ r_lfsr_q[3]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lfsr_q <= 8'hA5;
        end else begin
            r_lfsr_q <= w_lfsr_d;
        end
    end

    assign w_stall = r_lfsr_q[0];
`else
    assign w_stall = 1'b0;
`endif

    // Credit covers the SRAM stage as well as the FIFO, so the stage push never overflows.
    always_comb begin
        w_count       = {{c_cnt_w{1'b0}}, r_s1_valid_q} + {1'b0, w_fifo_count};
        instr_ready_o = (w_count < c_max_cnt) & ~w_stall & ~rst_i;
        w_accept      = instr_valid_i & instr_ready_o;

        w_misaligned   = |instr_addr_i[1:0];
        w_out_of_range = (instr_addr_i < MEM_BASE) || (instr_addr_i >= c_mem_end);
        w_fault        = w_misaligned | instr_we_i | w_out_of_range;
        w_code         = w_misaligned ? E_I_ADDR_MISALIGNED : E_I_ACCESS_FAULT;
        w_word_idx     = SRAM_AW'((instr_addr_i - MEM_BASE) >> 2);

        sram_req_o  = w_accept & ~w_fault;
        sram_addr_o = sram_req_o ? w_word_idx : '0;

        w_s1_valid_d  = w_accept;
        w_s1_except_d = w_accept & w_fault;
        w_s1_code_d   = w_accept ? w_code : E_I_ADDR_MISALIGNED;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid_q  <= 1'b0;
            r_s1_except_q <= 1'b0;
            r_s1_code_q   <= E_I_ADDR_MISALIGNED;
        end else begin
            r_s1_valid_q  <= w_s1_valid_d;
            r_s1_except_q <= w_s1_except_d;
            r_s1_code_q   <= w_s1_code_d;
        end
    end

    always_comb begin
        w_push_data.rdata         = r_s1_except_q ? '0 : sram_rdata_i;
        w_push_data.except_raised = r_s1_except_q;
        w_push_data.except_code   = r_s1_code_q;
    end

    assign w_pop = instr_valid_o & instr_ready_i;

    instr_resp_fifo #(
        .DEPTH   (MAX_OUTSTANDING),
        .COUNT_W (c_cnt_w)
    ) u_resp_fifo (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_push      (r_s1_valid_q),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign instr_valid_o         = ~w_fifo_empty;
    assign instr_rdata_o         = w_head.rdata;
    assign instr_except_raised_o = w_head.except_raised;
    assign instr_except_code_o   = w_head.except_code;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_responder
// Brief    : Directed self-checking bench for instr_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_responder;
    import len5_pkg::*;
    import fetch_pkg::*;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         instr_valid_i;
    logic         instr_ready_o;
    logic         instr_we_i;
    logic [63:0]  instr_addr_i;
    logic         instr_valid_o;
    logic         instr_ready_i;
    logic [31:0]  instr_rdata_o;
    logic         instr_except_raised_o;
    except_code_t instr_except_code_o;
    logic         sram_req_o;
    logic [9:0]   sram_addr_o;
    logic [31:0]  sram_rdata_i;

    typedef struct {
        logic [31:0] rdata;
        logic        raised;
        logic [3:0]  code;
        int          cyc;
    } mon_t;

    mon_t        mq[$];
    logic [31:0] sram_mem [1024];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    instr_mem_responder #(
        .MEM_BASE        (64'h0),
        .MEM_SIZE        (4096),
        .MAX_OUTSTANDING (3)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .instr_valid_i         (instr_valid_i),
        .instr_ready_o         (instr_ready_o),
        .instr_we_i            (instr_we_i),
        .instr_addr_i          (instr_addr_i),
        .instr_valid_o         (instr_valid_o),
        .instr_ready_i         (instr_ready_i),
        .instr_rdata_o         (instr_rdata_o),
        .instr_except_raised_o (instr_except_raised_o),
        .instr_except_code_o   (instr_except_code_o),
        .sram_req_o            (sram_req_o),
        .sram_addr_o           (sram_addr_o),
        .sram_rdata_i          (sram_rdata_i)
    );

    function automatic logic [31:0] exp_word(input int idx);
        logic [9:0] i10;
        i10 = idx[9:0];
        return (idx == 4) ? 32'hDEADBEEF : {16'hC0DE, 6'd0, i10};
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) sram_mem[i] = exp_word(i);
    end

    // 1-cycle synchronous SRAM model.
    always @(posedge clk) begin
        if (sram_req_o) sram_rdata_i <= sram_mem[sram_addr_o];
        cyc <= cyc + 1;
    end

    // Records every response handed over to fetch.
    always @(negedge clk) begin
        #2;
        if (instr_valid_o === 1'b1 && instr_ready_i === 1'b1)
            mq.push_back('{instr_rdata_o, instr_except_raised_o, instr_except_code_o, cyc});
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (instr_ready_o !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b want 0", instr_ready_o); end
        n_checks++; if (instr_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
        n_checks++; if (instr_rdata_o !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h want 0", instr_rdata_o); end
        n_checks++; if (instr_except_raised_o !== 1'b0) begin n_errors++; $display("FAIL reset_except: got %b want 0", instr_except_raised_o); end
        n_checks++; if (sram_req_o !== 1'b0) begin n_errors++; $display("FAIL reset_sram_req: got %b want 0", sram_req_o); end
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        n_checks++; if (instr_ready_o !== 1'b1) begin n_errors++; $display("FAIL post_reset_ready: got %b want 1", instr_ready_o); end
        n_checks++; if (instr_valid_o !== 1'b0) begin n_errors++; $display("FAIL post_reset_valid: got %b want 0", instr_valid_o); end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        instr_ready_i = 1'b1; instr_valid_i = 1'b1; instr_we_i = 1'b0; instr_addr_i = 64'h10;
        #1;
        n_checks++; if (sram_req_o !== 1'b1) begin n_errors++; $display("FAIL single_sram_req: got %b want 1", sram_req_o); end
        n_checks++; if (sram_addr_o !== 10'd4) begin n_errors++; $display("FAIL single_sram_addr: got %0d want 4", sram_addr_o); end
        @(negedge clk);
        instr_valid_i = 1'b0;
        #1;
        n_checks++; if (instr_valid_o !== 1'b0) begin n_errors++; $display("FAIL single_valid_t1: got %b want 0", instr_valid_o); end
        @(negedge clk);
        #1;
        n_checks++; if (instr_valid_o !== 1'b1) begin n_errors++; $display("FAIL single_valid_t2: got %b want 1", instr_valid_o); end
        n_checks++; if (instr_rdata_o !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_rdata: got %h want deadbeef", instr_rdata_o); end
        n_checks++; if (instr_except_raised_o !== 1'b0) begin n_errors++; $display("FAIL single_except: got %b want 0", instr_except_raised_o); end
        @(negedge clk);
        #1;
        n_checks++; if (instr_valid_o !== 1'b0) begin n_errors++; $display("FAIL single_valid_after_pop: got %b want 0", instr_valid_o); end
    endtask

    task automatic test_faults();
        int t0;
        mq.delete();
        @(negedge clk);
        instr_ready_i = 1'b1; instr_valid_i = 1'b1; instr_we_i = 1'b0; instr_addr_i = 64'h2;
        #1;
        t0 = cyc;
        n_checks++; if (sram_req_o !== 1'b0) begin n_errors++; $display("FAIL misal_sram_req: got %b want 0", sram_req_o); end
        @(negedge clk);
        instr_we_i = 1'b1; instr_addr_i = 64'h8;
        #1;
        n_checks++; if (sram_req_o !== 1'b0) begin n_errors++; $display("FAIL write_sram_req: got %b want 0", sram_req_o); end
        @(negedge clk);
        instr_valid_i = 1'b0; instr_we_i = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        n_checks++; if (mq.size() != 2) begin n_errors++; $display("FAIL faults_count: got %0d want 2", mq.size()); end
        if (mq.size() >= 2) begin
            n_checks++; if (mq[0].raised !== 1'b1 || mq[0].code !== E_I_ADDR_MISALIGNED || mq[0].rdata !== 32'h0)
                begin n_errors++; $display("FAIL faults_misal: got raised=%b code=%0d rdata=%h want 1/0/0", mq[0].raised, mq[0].code, mq[0].rdata); end
            n_checks++; if (mq[1].raised !== 1'b1 || mq[1].code !== E_I_ACCESS_FAULT || mq[1].rdata !== 32'h0)
                begin n_errors++; $display("FAIL faults_write: got raised=%b code=%0d rdata=%h want 1/1/0", mq[1].raised, mq[1].code, mq[1].rdata); end
            n_checks++; if (mq[0].cyc != t0 + 2) begin n_errors++; $display("FAIL faults_latency: got %0d want %0d", mq[0].cyc - t0, 2); end
        end
    endtask

    task automatic test_boundary();
        mq.delete();
        @(negedge clk);
        instr_ready_i = 1'b1; instr_valid_i = 1'b1; instr_we_i = 1'b0; instr_addr_i = 64'hFFC;
        #1;
        n_checks++; if (sram_req_o !== 1'b1) begin n_errors++; $display("FAIL top_word_req: got %b want 1", sram_req_o); end
        n_checks++; if (sram_addr_o !== 10'd1023) begin n_errors++; $display("FAIL top_word_addr: got %0d want 1023", sram_addr_o); end
        @(negedge clk);
        instr_addr_i = 64'h1000;
        #1;
        n_checks++; if (sram_req_o !== 1'b0) begin n_errors++; $display("FAIL end_addr_req: got %b want 0", sram_req_o); end
        @(negedge clk);
        instr_addr_i = 64'h0000_0001_0000_0010;
        #1;
        n_checks++; if (sram_req_o !== 1'b0) begin n_errors++; $display("FAIL high_addr_req: got %b want 0", sram_req_o); end
        @(negedge clk);
        instr_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        n_checks++; if (mq.size() != 3) begin n_errors++; $display("FAIL boundary_count: got %0d want 3", mq.size()); end
        if (mq.size() >= 3) begin
            n_checks++; if (mq[0].raised !== 1'b0 || mq[0].rdata !== exp_word(1023))
                begin n_errors++; $display("FAIL boundary_top: got raised=%b rdata=%h want 0/%h", mq[0].raised, mq[0].rdata, exp_word(1023)); end
            n_checks++; if (mq[1].raised !== 1'b1 || mq[1].code !== E_I_ACCESS_FAULT)
                begin n_errors++; $display("FAIL boundary_end: got raised=%b code=%0d want 1/1", mq[1].raised, mq[1].code); end
            n_checks++; if (mq[2].raised !== 1'b1 || mq[2].code !== E_I_ACCESS_FAULT)
                begin n_errors++; $display("FAIL boundary_high: got raised=%b code=%0d want 1/1", mq[2].raised, mq[2].code); end
        end
    endtask

    task automatic test_backpressure();
        bit [6:0] exp_rdy;
        int       idx;
        exp_rdy = 7'b1000111;
        idx     = 0;
        mq.delete();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 5) instr_ready_i = 1'b1;
            else if (k == 0) instr_ready_i = 1'b0;
            instr_valid_i = 1'b1; instr_we_i = 1'b0; instr_addr_i = 64'(idx * 4);
            #1;
            n_checks++; if (instr_ready_o !== exp_rdy[k]) begin n_errors++; $display("FAIL bp_ready_k%0d: got %b want %b", k, instr_ready_o, exp_rdy[k]); end
            if (k == 3 || k == 4) begin
                n_checks++; if (instr_valid_o !== 1'b1 || instr_rdata_o !== exp_word(0))
                    begin n_errors++; $display("FAIL bp_hold_k%0d: got valid=%b rdata=%h want 1/%h", k, instr_valid_o, instr_rdata_o, exp_word(0)); end
            end
            if (instr_ready_o === 1'b1) idx++;
        end
        @(negedge clk);
        instr_valid_i = 1'b0;
        repeat (6) @(negedge clk);
        #3;
        n_checks++; if (mq.size() != 4) begin n_errors++; $display("FAIL bp_count: got %0d want 4", mq.size()); end
        for (int i = 0; i < 4 && i < mq.size(); i++) begin
            n_checks++; if (mq[i].raised !== 1'b0 || mq[i].rdata !== exp_word(i))
                begin n_errors++; $display("FAIL bp_order_%0d: got raised=%b rdata=%h want 0/%h", i, mq[i].raised, mq[i].rdata, exp_word(i)); end
        end
    endtask

    task automatic test_streaming();
        int stalls;
        int t0;
        int j;
        stalls = 0;
        mq.delete();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            instr_ready_i = 1'b1; instr_valid_i = 1'b1; instr_we_i = 1'b0;
            if (i < 7)       instr_addr_i = 64'h200 + 64'(4 * i);
            else if (i == 7) instr_addr_i = 64'h203;
            else             instr_addr_i = 64'h200 + 64'(4 * (i - 1));
            #1;
            if (i == 0) t0 = cyc;
            if (instr_ready_o !== 1'b1) stalls++;
        end
        @(negedge clk);
        instr_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        #3;
        n_checks++; if (stalls != 0) begin n_errors++; $display("FAIL stream_stalls: got %0d want 0", stalls); end
        n_checks++; if (mq.size() != 17) begin n_errors++; $display("FAIL stream_count: got %0d want 17", mq.size()); end
        if (mq.size() == 17) begin
            n_checks++; if (mq[0].cyc != t0 + 2) begin n_errors++; $display("FAIL stream_latency: got %0d want 2", mq[0].cyc - t0); end
            for (int i = 0; i < 17; i++) begin
                j = (i < 7) ? i : i - 1;
                n_checks++; if (mq[i].cyc != mq[0].cyc + i) begin n_errors++; $display("FAIL stream_cycle_%0d: got %0d want %0d", i, mq[i].cyc, mq[0].cyc + i); end
                if (i == 7) begin
                    n_checks++; if (mq[i].raised !== 1'b1 || mq[i].code !== E_I_ADDR_MISALIGNED || mq[i].rdata !== 32'h0)
                        begin n_errors++; $display("FAIL stream_misal: got raised=%b code=%0d rdata=%h want 1/0/0", mq[i].raised, mq[i].code, mq[i].rdata); end
                end else begin
                    n_checks++; if (mq[i].raised !== 1'b0 || mq[i].rdata !== exp_word(128 + j))
                        begin n_errors++; $display("FAIL stream_data_%0d: got raised=%b rdata=%h want 0/%h", i, mq[i].raised, mq[i].rdata, exp_word(128 + j)); end
                end
            end
        end
    endtask

    task automatic test_reset_outstanding();
        int t0;
        mq.delete();
        @(negedge clk);
        instr_ready_i = 1'b0; instr_valid_i = 1'b1; instr_we_i = 1'b0; instr_addr_i = 64'h40;
        @(negedge clk);
        instr_addr_i = 64'h44;
        @(negedge clk);
        instr_valid_i = 1'b0; rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        n_checks++; if (instr_valid_o !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid: got %b want 0", instr_valid_o); end
        n_checks++; if (instr_ready_o !== 1'b1) begin n_errors++; $display("FAIL rst_out_ready: got %b want 1", instr_ready_o); end
        instr_ready_i = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        n_checks++; if (mq.size() != 0) begin n_errors++; $display("FAIL rst_out_stale: got %0d responses want 0", mq.size()); end
        @(negedge clk);
        instr_valid_i = 1'b1; instr_addr_i = 64'h48;
        #1;
        t0 = cyc;
        @(negedge clk);
        instr_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        n_checks++; if (mq.size() != 1) begin n_errors++; $display("FAIL rst_out_next_count: got %0d want 1", mq.size()); end
        if (mq.size() == 1) begin
            n_checks++; if (mq[0].rdata !== exp_word(18) || mq[0].raised !== 1'b0)
                begin n_errors++; $display("FAIL rst_out_next_data: got %h want %h", mq[0].rdata, exp_word(18)); end
            n_checks++; if (mq[0].cyc != t0 + 2) begin n_errors++; $display("FAIL rst_out_next_latency: got %0d want 2", mq[0].cyc - t0); end
        end
    endtask

    initial begin
        rst_i = 1'b1; instr_valid_i = 1'b0; instr_we_i = 1'b0;
        instr_addr_i = 64'h0; instr_ready_i = 1'b0;
        test_reset();
        test_single_read();
        test_faults();
        test_boundary();
        test_backpressure();
        test_streaming();
        test_reset_outstanding();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
